// File: rtl/axi_slave_pkg.sv
// Shared AXI3 widths, response codes and FSM state encoding for the SRAM-backed slave.
package axi_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Word-addressed SRAM with byte-enable write port and registered read that holds
// its output when no read is requested.
module sram_array
  import axi_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [AXI_STRB_BITS-1:0] wstrb,
  input  logic [AXI_DATA_BITS-1:0] wdata,
  input  logic                     re,
  input  logic [AW-1:0]            raddr,
  output logic [AXI_DATA_BITS-1:0] rdata
);

  logic [AXI_DATA_BITS-1:0] mem [DEPTH];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < AXI_STRB_BITS; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating one interconnect port with an on-chip SRAM; serves one
// write or read burst at a time and alternates direction on simultaneous requests.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int AW_IDX = $clog2(DEPTH)
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_IDS_BITS-1:0]  AWID,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_DATA_BITS-1:0] WDATA,
  input  logic [AXI_STRB_BITS-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [AXI_IDS_BITS-1:0]  ARID,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and AWREADY/ARREADY may depend combinationally on valid.

  state_t                   state, state_nxt;
  logic [AXI_IDS_BITS-1:0]  id_q;
  logic [AW_IDX-1:0]        idx_q;
  logic [AXI_LEN_BITS-1:0]  len_q, cnt_q;
  logic                     last_wr, wlast_early;
  logic [1:0]               bresp_q;
  logic                     pick_wr, beat_last;
  logic                     aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic                     sram_re;
  logic [AW_IDX-1:0]        sram_raddr;
  logic                     unused_bits;

  assign unused_bits = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                         AWADDR[AXI_ADDR_BITS-1:AW_IDX+2], AWADDR[1:0],
                         ARADDR[AXI_ADDR_BITS-1:AW_IDX+2], ARADDR[1:0]};

  // Ties alternate: last_wr resets low so the first tie goes to the write.
  assign pick_wr   = AWVALID & (~ARVALID | ~last_wr);
  assign beat_last = (cnt_q == len_q);
  assign aw_hs     = AWVALID & AWREADY;
  assign ar_hs     = ARVALID & ARREADY;
  assign w_hs      = WVALID & WREADY;
  assign b_hs      = BVALID & BREADY;
  assign r_hs      = RVALID & RREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (aw_hs)      state_nxt = ST_WDATA;
        else if (ar_hs) state_nxt = ST_RDATA;
      end
      ST_WDATA: if (w_hs && beat_last) state_nxt = ST_WRESP;
      ST_WRESP: if (b_hs)              state_nxt = ST_IDLE;
      ST_RDATA: if (r_hs && beat_last) state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    ARREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    case (state)
      ST_IDLE: begin
        AWREADY = ARESETn & AWVALID & pick_wr;
        ARREADY = ARESETn & ARVALID & ~pick_wr;
      end
      ST_WDATA: WREADY = 1'b1;
      ST_WRESP: BVALID = 1'b1;
      ST_RDATA: begin
        RVALID = 1'b1;
        RLAST  = beat_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      last_wr     <= 1'b0;
      wlast_early <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else if (aw_hs) begin
      id_q        <= AWID;
      idx_q       <= AWADDR[AW_IDX+1:2];
      len_q       <= AWLEN;
      cnt_q       <= '0;
      last_wr     <= 1'b1;
      wlast_early <= 1'b0;
    end else if (ar_hs) begin
      id_q    <= ARID;
      idx_q   <= ARADDR[AW_IDX+1:2];
      len_q   <= ARLEN;
      cnt_q   <= '0;
      last_wr <= 1'b0;
    end else if (w_hs) begin
      idx_q <= idx_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
      // OKAY only when WLAST lands on the final beat and was never seen before it.
      if (beat_last)  bresp_q     <= (WLAST && !wlast_early) ? RESP_OKAY : RESP_SLVERR;
      else if (WLAST) wlast_early <= 1'b1;
    end else if (r_hs && !beat_last) begin
      idx_q <= idx_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Reads are issued only on AR acceptance or an accepted non-final beat, so the
  // SRAM output register holds RDATA steady while the master stalls.
  assign sram_re    = ar_hs | (r_hs & ~beat_last);
  assign sram_raddr = ar_hs ? ARADDR[AW_IDX+1:2] : idx_q + 1'b1;

  sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW_IDX)
  ) u_sram (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (w_hs),
    .waddr (idx_q),
    .wstrb (WSTRB),
    .wdata (WDATA),
    .re    (sram_re),
    .raddr (sram_raddr),
    .rdata (RDATA)
  );

  assign BID       = id_q;
  assign RID       = id_q;
  assign BRESP     = bresp_q;
  assign RRESP     = RESP_OKAY;
  assign dbg_state = state;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave: single/burst/partial writes,
// stalled reads, direction tie-break, SLVERR, index wrap and mid-burst reset.
module tb_axi_sram_slave;
  import axi_slave_pkg::*;

  logic        ACLK, ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP, dbg_state;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick();
    tick();
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
  endtask

  // Driver tasks: all start and end at 1 time unit after a rising edge.
  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("awready", 32'(AWREADY), 32'd1);
    tick();
    AWVALID = 1'b0;
    check("wready_after_aw", 32'(WREADY), 32'd1);
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    @(negedge ACLK);
    while (!WREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("wready", 32'(WREADY), 32'd1);
    tick();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic do_b(input logic [7:0] id, input logic [1:0] resp);
    check("bvalid_next_cycle", 32'(BVALID), 32'd1);
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bid", 32'(BID), 32'(id));
    check("bresp", 32'(BRESP), 32'(resp));
    tick();
    BREADY = 1'b0;
    check("bvalid_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("arready", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    check("rvalid_next_cycle", 32'(RVALID), 32'd1);
  endtask

  task automatic do_r(input logic [7:0] id, input logic last);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    RREADY = 1'b1;
    @(negedge ACLK);
    check("rvalid", 32'(RVALID), 32'd1);
    check("rdata", RDATA, e);
    check("rlast", 32'(RLAST), 32'(last));
    check("rid", 32'(RID), 32'(id));
    check("rresp", 32'(RRESP), 32'(RESP_OKAY));
    tick();
    RREADY = 1'b0;
  endtask

  task automatic r_stall(input logic last);
    RREADY = 1'b0;
    @(negedge ACLK);
    check("rvalid_stall", 32'(RVALID), 32'd1);
    check("rdata_stall", RDATA, (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx);
    check("rlast_stall", 32'(RLAST), 32'(last));
    tick();
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    AWVALID = 1'b1; ARVALID = 1'b1;

    // Reset values, with both address channels requesting during reset
    tick();
    tick();
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rlast", 32'(RLAST), 32'd0);
    check("rst_bid", 32'(BID), 32'd0);
    check("rst_rid", 32'(RID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    check("rst_rresp", 32'(RRESP), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();

    // Single write then read back
    do_aw(8'h21, 32'h0000_0010, 4'd0);
    do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    do_b(8'h21, RESP_OKAY);
    exp_q.push_back(32'hDEAD_BEEF);
    do_ar(8'h22, 32'h0000_0010, 4'd0);
    do_r(8'h22, 1'b1);
    check("rvalid_after_last", 32'(RVALID), 32'd0);

    // 4-beat burst, read back with RREADY toggling
    do_aw(8'h44, 32'h0000_0100, 4'd3);
    for (int i = 1; i <= 4; i++) do_w(32'(i), 4'hF, i == 4);
    do_b(8'h44, RESP_OKAY);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    do_ar(8'h45, 32'h0000_0100, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      r_stall(i == 4);
      do_r(8'h45, i == 4);
    end
    check("rvalid_after_burst", 32'(RVALID), 32'd0);

    // Partial strobe overwrite
    do_aw(8'h10, 32'h0000_0200, 4'd0);
    do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    do_b(8'h10, RESP_OKAY);
    do_aw(8'h11, 32'h0000_0200, 4'd0);
    do_w(32'h0000_0000, 4'b0101, 1'b1);
    do_b(8'h11, RESP_OKAY);
    exp_q.push_back(32'hFF00_FF00);
    do_ar(8'h12, 32'h0000_0200, 4'd0);
    do_r(8'h12, 1'b1);

    // Index wrap from DEPTH-1 to 0; upper address bits ignored
    do_aw(8'h07, 32'h0000_0FFC, 4'd1);
    do_w(32'hA5A5_0001, 4'hF, 1'b0);
    do_w(32'hA5A5_0002, 4'hF, 1'b1);
    do_b(8'h07, RESP_OKAY);
    exp_q.push_back(32'hA5A5_0002);
    do_ar(8'h08, 32'h0000_1000, 4'd0);
    do_r(8'h08, 1'b1);
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0002);
    do_ar(8'h09, 32'h0000_0FFC, 4'd1);
    do_r(8'h09, 1'b0);
    do_r(8'h09, 1'b1);

    // WLAST on beat 2 of 4 -> SLVERR after the 4th beat, data still written
    do_aw(8'h09, 32'h0000_0300, 4'd3);
    do_w(32'h0000_0031, 4'hF, 1'b0);
    do_w(32'h0000_0032, 4'hF, 1'b1);
    do_w(32'h0000_0033, 4'hF, 1'b0);
    check("bvalid_before_last", 32'(BVALID), 32'd0);
    do_w(32'h0000_0034, 4'hF, 1'b0);
    do_b(8'h09, RESP_SLVERR);
    exp_q.push_back(32'h0000_0034);
    do_ar(8'h0A, 32'h0000_030C, 4'd0);
    do_r(8'h0A, 1'b1);

    // Simultaneous AW/AR twice: write wins the first tie, read the second
    do_reset();
    AWID = 8'h1A; AWADDR = 32'h0000_0400; AWLEN = 4'd0; AWVALID = 1'b1;
    ARID = 8'h03; ARADDR = 32'h0000_0010; ARLEN = 4'd0; ARVALID = 1'b1;
    @(negedge ACLK);
    check("tie1_awready", 32'(AWREADY), 32'd1);
    check("tie1_arready", 32'(ARREADY), 32'd0);
    tick();
    AWVALID = 1'b0;
    check("tie1_arready_busy", 32'(ARREADY), 32'd0);
    do_w(32'hCAFE_0001, 4'hF, 1'b1);
    do_b(8'h1A, RESP_OKAY);
    AWID = 8'h55; AWADDR = 32'h0000_0404; AWVALID = 1'b1;
    @(negedge ACLK);
    check("tie2_arready", 32'(ARREADY), 32'd1);
    check("tie2_awready", 32'(AWREADY), 32'd0);
    tick();
    ARVALID = 1'b0;
    check("tie2_rvalid", 32'(RVALID), 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    do_r(8'h03, 1'b1);
    do_aw(8'h55, 32'h0000_0404, 4'd0);
    do_w(32'hCAFE_0002, 4'hF, 1'b1);
    do_b(8'h55, RESP_OKAY);
    exp_q.push_back(32'hCAFE_0001);
    exp_q.push_back(32'hCAFE_0002);
    do_ar(8'h56, 32'h0000_0400, 4'd1);
    do_r(8'h56, 1'b0);
    do_r(8'h56, 1'b1);

    // Reset asserted during beat 2 of a 4-beat read
    exp_q.push_back(32'd1);
    do_ar(8'h66, 32'h0000_0100, 4'd3);
    do_r(8'h66, 1'b0);
    RREADY = 1'b0;
    #2;
    ARESETn = 1'b0;
    #1;
    check("midrst_rvalid", 32'(RVALID), 32'd0);
    check("midrst_rlast", 32'(RLAST), 32'd0);
    check("midrst_rdata", RDATA, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    exp_q.push_back(32'd2);
    do_ar(8'h67, 32'h0000_0104, 4'd0);
    do_r(8'h67, 1'b1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
